sprite_line_scheduler: RTL and testbench
========================================

Name: sprite_line_scheduler

Overview:
- Shares one sprite_v1-style line engine between N sprite table entries.
- Once per display line, scans a small sprite table and selects the lowest-index enabled sprite covering the requested line.
- Issues a one-cycle start, x position and sprite row to the engine, then waits for the engine's done pulse.
- Sits between the display timing generator and the sprite engine, in the pixel clock domain.

Parameters:
- CORDW, 12, screen coordinate width in bits.
- NSPR, 8, number of sprite table entries (2..16).
- IDW, 3, entry index width; must equal clog2(NSPR).
- SPR_HEIGHT, 8, sprite height in lines (1..64).

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, asynchronous active-high reset.
- line, input, 1, one-cycle pulse requesting a schedule for line line_y.
- line_y, input, CORDW, line to schedule; sampled on line.
- tbl_we, input, 1, table write strobe.
- tbl_addr, input, IDW, table entry to write.
- tbl_x, input, CORDW, entry x position.
- tbl_y, input, CORDW, entry top line.
- tbl_en, input, 1, entry enable.
- spr_done, input, 1, one-cycle pulse: engine finished drawing the line.
- spr_start, output, 1, one-cycle start pulse to the engine.
- spr_x, output, CORDW, x position of the selected sprite.
- spr_id, output, IDW, index of the selected sprite.
- spr_row, output, 6, row within the sprite (line_y − y).
- busy, output, 1, high in every state except IDLE.
- ovf, output, 1, one-cycle pulse: more than one sprite hit the line.
- late, output, 1, one-cycle pulse: line arrived while busy.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - All outputs are 0: spr_start, spr_x, spr_id, spr_row, busy, ovf, late.
  - All table entries are cleared (en=0, x=0, y=0).
- Table:
  - NSPR entries of {x, y, en} held in registers.
  - A write on tbl_we is visible to the scan from the next cycle.
  - A write while busy is legal. An entry already scanned is not re-evaluated for the current line.
- Hit rule:
  - en=1, and line_y ≥ y, and line_y < y+SPR_HEIGHT.
  - The compare is done at CORDW+1 bits, so y near the top of the range does not wrap.
  - No hit for y+SPR_HEIGHT beyond the coordinate range unless line_y is inside it.
- States:
  - IDLE: on line, latch line_y, set idx=0, clear hit/ovf flags, go to SCAN.
  - SCAN: evaluates entry idx once per cycle, so it lasts exactly NSPR cycles.
    - First hit: latch spr_x, spr_id and spr_row (row = line_y − y, low 6 bits).
    - Any later hit: set the overflow flag.
    - After entry NSPR−1: go to ISSUE if any hit, otherwise go to IDLE.
  - ISSUE: spr_start=1 for exactly one cycle, go to WAIT. spr_x, spr_id and spr_row stay stable from ISSUE until the next scan latches new values.
  - WAIT: on spr_done, go to IDLE. The start-to-done interval is unbounded.
- ovf: pulses one cycle in the cycle SCAN exits, when two or more hits were found.
- Latency:
  - line to spr_start = NSPR+1 cycles (IDLE sample, NSPR scan cycles, ISSUE).
  - Lines with no hit return to IDLE after NSPR+1 cycles with no start.
- line while busy (SCAN, ISSUE, WAIT):
  - late pulses one cycle.
  - The current operation is abandoned; no spr_start is issued if the line arrives in SCAN.
  - The new line_y is latched and SCAN restarts at idx=0.
  - A spr_done arriving in the same cycle is ignored.
- spr_done outside WAIT: ignored.
- Priority: the lowest index wins; nothing is stored for losing sprites.
- rst asserted mid-scan or mid-wait: immediate return to IDLE. The table is cleared and no pulse is emitted.

Test Plan:
- Entry 2 = {x=16, y=16, en=1}, others disabled; line with line_y=18 → spr_start at cycle 9 after line (NSPR=8), spr_x=16, spr_id=2, spr_row=2, ovf=0.
- Same table, line_y=24 and line_y=15 → no spr_start, busy returns to 0 after 9 cycles.
- Entries 1 and 5 both y=16 en=1, line_y=16 → spr_id=1 and ovf pulses once at SCAN exit.
- Start issued, second line pulse before spr_done → late=1 for one cycle, new scan, second spr_start 9 cycles later; earlier spr_done ignored.
- Entry y=4090 (CORDW=12), line_y=4095 → hit with spr_row=5; line_y=1 → no hit (no wrap).
- Assert rst during WAIT → outputs 0 immediately, table cleared; next line → no spr_start.

Source files
------------

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: once per line, picks the lowest-index enabled sprite covering line_y and
// hands its x position and row to a single shared sprite line engine.
module sprite_line_scheduler #(
   parameter int CORDW      = 12,
   parameter int NSPR       = 8,
   parameter int IDW        = 3,
   parameter int SPR_HEIGHT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             line,
   input  logic [CORDW-1:0] line_y,
   input  logic             tbl_we,
   input  logic [IDW-1:0]   tbl_addr,
   input  logic [CORDW-1:0] tbl_x,
   input  logic [CORDW-1:0] tbl_y,
   input  logic             tbl_en,
   input  logic             spr_done,
   output logic             spr_start,
   output logic [CORDW-1:0] spr_x,
   output logic [IDW-1:0]   spr_id,
   output logic [5:0]       spr_row,
   output logic             busy,
   output logic             ovf,
   output logic             late
);
   typedef enum logic [1:0] {IDLE, SCAN, ISSUE, WAIT} state_t;
   state_t state;
   logic [CORDW-1:0] tx [NSPR];
   logic [CORDW-1:0] ty [NSPR];
   logic [NSPR-1:0]  ten;
   logic [CORDW-1:0] ly;
   logic [IDW-1:0]   idx;
   logic             hit_any, multi;
   logic [CORDW:0]   ly_ext, y_ext, y_end;
   logic [5:0]       row;
   logic             hit, last, go;
   // One extra bit keeps y+SPR_HEIGHT from wrapping near the top of the coordinate range.
   assign ly_ext = {1'b0, ly};
   assign y_ext  = {1'b0, ty[idx]};
   assign y_end  = y_ext + (CORDW+1)'(SPR_HEIGHT);
   assign hit    = ten[idx] && (ly_ext >= y_ext) && (ly_ext < y_end);
   assign row    = 6'(ly - ty[idx]);
   assign last   = idx == IDW'(NSPR-1);
   assign go     = hit_any || hit;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         spr_start <= 1'b0;
         spr_x     <= '0;
         spr_id    <= '0;
         spr_row   <= '0;
         busy      <= 1'b0;
         ovf       <= 1'b0;
         late      <= 1'b0;
         ly        <= '0;
         idx       <= '0;
         hit_any   <= 1'b0;
         multi     <= 1'b0;
         ten       <= '0;
         for (int i = 0; i < NSPR; i++) begin
            tx[i] <= '0;
            ty[i] <= '0;
         end
      end else begin
         if (tbl_we) begin
            tx[tbl_addr]  <= tbl_x;
            ty[tbl_addr]  <= tbl_y;
            ten[tbl_addr] <= tbl_en;
         end
         spr_start <= 1'b0;
         ovf       <= 1'b0;
         late      <= 1'b0;
         if (line) begin
            late    <= state != IDLE;
            ly      <= line_y;
            idx     <= '0;
            hit_any <= 1'b0;
            multi   <= 1'b0;
            state   <= SCAN;
            busy    <= 1'b1;
         end else begin
            case (state)
               SCAN: begin
                  if (hit && !hit_any) begin
                     spr_x   <= tx[idx];
                     spr_id  <= idx;
                     spr_row <= row;
                  end
                  hit_any <= go;
                  multi   <= multi || (hit && hit_any);
                  idx     <= idx + 1'b1;
                  if (last) begin
                     ovf       <= multi || (hit && hit_any);
                     spr_start <= go;
                     busy      <= go;
                     state     <= go ? ISSUE : IDLE;
                  end
               end
               ISSUE: state <= WAIT;
               WAIT: if (spr_done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: directed scoreboard bench; a table model predicts each line's outcome.
module tb_sprite_line_scheduler;
   localparam int CORDW = 12, NSPR = 8, IDW = 3, H = 8;
   logic             clk = 0, rst = 1, line = 0, tbl_we = 0, tbl_en = 0, spr_done = 0;
   logic [CORDW-1:0] line_y = '0, tbl_x = '0, tbl_y = '0;
   logic [IDW-1:0]   tbl_addr = '0;
   logic             spr_start, busy, ovf, late;
   logic [CORDW-1:0] spr_x;
   logic [IDW-1:0]   spr_id;
   logic [5:0]       spr_row;
   typedef struct {bit hit; int x; int id; int row; int ovf; int late;} exp_t;
   exp_t q[$];
   int mx[NSPR], my[NSPR];
   bit men[NSPR];
   int total = 0, passed = 0;

   sprite_line_scheduler #(.CORDW(CORDW), .NSPR(NSPR), .IDW(IDW), .SPR_HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .line(line), .line_y(line_y), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
      .tbl_x(tbl_x), .tbl_y(tbl_y), .tbl_en(tbl_en), .spr_done(spr_done), .spr_start(spr_start),
      .spr_x(spr_x), .spr_id(spr_id), .spr_row(spr_row), .busy(busy), .ovf(ovf), .late(late));

   always #5 clk = ~clk;

   task automatic chk(string tag, int obs, int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic chk_zero(string tag);
      chk(tag, int'({spr_start, spr_x, spr_id, spr_row, busy, ovf, late}), 0);
   endtask

   task automatic wr(int a, int x, int y, bit en);
      tbl_we = 1; tbl_addr = IDW'(a); tbl_x = CORDW'(x); tbl_y = CORDW'(y); tbl_en = en;
      mx[a] = x; my[a] = y; men[a] = en;
      @(posedge clk); #1 tbl_we = 0;
   endtask

   task automatic pulse(int y, bit done);
      line = 1; line_y = CORDW'(y); spr_done = done;
      @(posedge clk); #1 line = 0; spr_done = 0;
   endtask

   task automatic send_line(int y, int exp_late, bit done);
      exp_t e;
      int n = 0;
      e = '{0, 0, 0, 0, 0, exp_late};
      for (int i = 0; i < NSPR; i++)
         if (men[i] && y >= my[i] && y < my[i] + H) begin
            if (n == 0) begin e.hit = 1; e.x = mx[i]; e.id = i; e.row = y - my[i]; end
            n++;
         end
      e.ovf = (n > 1) ? 1 : 0;
      q.push_back(e);
      pulse(y, done);
   endtask

   // Observes the cycle after the sampling edge (k=0) through one cycle past the expected start.
   task automatic check_line(string tag);
      exp_t e;
      int st_cnt = 0, st_at = -1, ovf_cnt = 0, ovf_at = -1, late_cnt = 0;
      e = q.pop_front();
      for (int k = 0; k <= NSPR + 1; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (spr_start) begin st_cnt++; st_at = k; end
         if (ovf) begin ovf_cnt++; ovf_at = k; end
         if (late) late_cnt++;
      end
      chk({tag, "_starts"}, st_cnt, e.hit ? 1 : 0);
      chk({tag, "_start_at"}, st_at, e.hit ? NSPR : -1);
      chk({tag, "_ovf"}, ovf_cnt, e.ovf);
      if (e.ovf) chk({tag, "_ovf_at"}, ovf_at, NSPR);
      chk({tag, "_late"}, late_cnt, e.late);
      chk({tag, "_busy"}, int'(busy), e.hit ? 1 : 0);
      if (e.hit) begin
         chk({tag, "_x"}, int'(spr_x), e.x);
         chk({tag, "_id"}, int'(spr_id), e.id);
         chk({tag, "_row"}, int'(spr_row), e.row);
      end
   endtask

   task automatic finish_draw(string tag);
      repeat (3) @(posedge clk);
      #1 chk({tag, "_wait_busy"}, int'(busy), 1);
      spr_done = 1;
      @(posedge clk); #1 spr_done = 0;
      chk({tag, "_idle"}, int'(busy), 0);
   endtask

   initial begin
      for (int i = 0; i < NSPR; i++) begin mx[i] = 0; my[i] = 0; men[i] = 0; end
      #1 chk_zero("reset_outs");
      repeat (2) @(posedge clk);
      #1 rst = 0;
      spr_done = 1;
      @(posedge clk); #1 spr_done = 0;
      chk("done_in_idle", int'(busy), 0);

      wr(2, 16, 16, 1);
      send_line(18, 0, 0); check_line("single");
      finish_draw("single");
      send_line(24, 0, 0); check_line("below");
      send_line(15, 0, 0); check_line("above");
      send_line(23, 0, 0); check_line("last_row");
      finish_draw("last_row");

      wr(1, 40, 16, 1);
      wr(5, 80, 16, 1);
      send_line(16, 0, 0); check_line("prio");
      finish_draw("prio");

      send_line(17, 0, 0); check_line("first");
      send_line(20, 1, 1); check_line("late_wait");
      finish_draw("late_wait");

      pulse(30, 0);
      repeat (3) @(posedge clk);
      #1 wr(6, 200, 28, 1);
      send_line(30, 1, 0); check_line("late_scan");
      finish_draw("late_scan");

      wr(1, 0, 0, 0); wr(2, 0, 0, 0); wr(5, 0, 0, 0); wr(6, 0, 0, 0);
      wr(3, 100, 4090, 1);
      send_line(4095, 0, 0); check_line("top");
      finish_draw("top");
      send_line(1, 0, 0); check_line("nowrap");
      send_line(4089, 0, 0); check_line("just_above");

      send_line(4090, 0, 0); check_line("pre_rst");
      #2 rst = 1;
      #1 chk_zero("rst_wait_outs");
      @(posedge clk); #1 rst = 0;
      for (int i = 0; i < NSPR; i++) men[i] = 0;
      send_line(4095, 0, 0); check_line("after_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
